// File: rtl/muldiv_sequencer_if.sv
// Handshake bundle between the EX stage and the RV32M multiply/divide sequencer.
// The master side is the pipeline; the slave side is the sequencer.
interface muldiv_sequencer_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [2:0]      Funct3;
  logic [XLEN-1:0] SrcA;
  logic [XLEN-1:0] SrcB;
  logic            flush;
  logic            Stall;
  logic            Busy;
  logic            Done;
  logic [XLEN-1:0] Result;

  modport master (
    output start, Funct3, SrcA, SrcB, flush,
    input  Stall, Busy, Done, Result
  );

  modport slave (
    input  start, Funct3, SrcA, SrcB, flush,
    output Stall, Busy, Done, Result
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// Iterative RV32M unit: shift-add multiplier and restoring divider that share one
// accumulator pair, sequenced by an IDLE/RUN/DONE FSM with an XLEN-cycle counter.
module muldiv_sequencer #(
  parameter int XLEN = 32
) (
  input  logic               clk,
  input  logic               reset,
  muldiv_sequencer_if.slave  bus
);
  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_r;
  logic [CW-1:0]   counter_r;
  logic [2:0]      funct3_r;
  logic            is_div_r;
  logic            neg_q_r;
  logic            neg_r_r;
  logic [XLEN-1:0] hi_r;
  logic [XLEN-1:0] lo_r;
  logic [XLEN-1:0] op_r;
  logic [XLEN-1:0] result_r;
  logic            done_r;
  logic            busy_r;

  logic            signed_a_s;
  logic            signed_b_s;
  logic            a_neg_s;
  logic            b_neg_s;
  logic [XLEN-1:0] mag_a_s;
  logic [XLEN-1:0] mag_b_s;
  logic            special_s;
  logic [XLEN-1:0] special_val_s;
  logic [XLEN:0]   sum_s;
  logic [XLEN:0]   diff_s;
  logic [XLEN-1:0] hi_nxt_s;
  logic [XLEN-1:0] lo_nxt_s;
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0] fin_s;

  function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic neg);
    cond_neg = neg ? (~v + {{(XLEN-1){1'b0}}, 1'b1}) : v;
  endfunction

  function automatic logic [2*XLEN-1:0] cond_neg_wide(input logic [2*XLEN-1:0] v, input logic neg);
    cond_neg_wide = neg ? (~v + {{(2*XLEN-1){1'b0}}, 1'b1}) : v;
  endfunction

  // Operand sign handling and divide fast-path detection on the raw inputs.
  always_comb begin
    signed_a_s = 1'b0;
    signed_b_s = 1'b0;
    case (bus.Funct3)
      3'b001:  begin signed_a_s = 1'b1; signed_b_s = 1'b1; end
      3'b010:  begin signed_a_s = 1'b1; signed_b_s = 1'b0; end
      3'b100:  begin signed_a_s = 1'b1; signed_b_s = 1'b1; end
      3'b110:  begin signed_a_s = 1'b1; signed_b_s = 1'b1; end
      default: begin signed_a_s = 1'b0; signed_b_s = 1'b0; end
    endcase
    a_neg_s = signed_a_s & bus.SrcA[XLEN-1];
    b_neg_s = signed_b_s & bus.SrcB[XLEN-1];
    mag_a_s = cond_neg(bus.SrcA, a_neg_s);
    mag_b_s = cond_neg(bus.SrcB, b_neg_s);

    special_s     = 1'b0;
    special_val_s = {XLEN{1'b0}};
    if (bus.Funct3[2] && (bus.SrcB == {XLEN{1'b0}})) begin
      special_s     = 1'b1;
      special_val_s = bus.Funct3[1] ? bus.SrcA : {XLEN{1'b1}};
    end else if (bus.Funct3[2] && !bus.Funct3[0] &&
                 (bus.SrcA == {1'b1, {(XLEN-1){1'b0}}}) && (bus.SrcB == {XLEN{1'b1}})) begin
      special_s     = 1'b1;
      special_val_s = bus.Funct3[1] ? {XLEN{1'b0}} : bus.SrcA;
    end else begin
      special_s     = 1'b0;
      special_val_s = {XLEN{1'b0}};
    end
  end

  // One engine iteration: hi/lo hold product or remainder/quotient, op_r the fixed operand.
  always_comb begin
    sum_s    = {(XLEN+1){1'b0}};
    diff_s   = {(XLEN+1){1'b0}};
    hi_nxt_s = hi_r;
    lo_nxt_s = lo_r;
    if (is_div_r) begin
      diff_s = {hi_r, lo_r[XLEN-1]} - {1'b0, op_r};
      if (!diff_s[XLEN]) begin
        hi_nxt_s = diff_s[XLEN-1:0];
        lo_nxt_s = {lo_r[XLEN-2:0], 1'b1};
      end else begin
        hi_nxt_s = {hi_r[XLEN-2:0], lo_r[XLEN-1]};
        lo_nxt_s = {lo_r[XLEN-2:0], 1'b0};
      end
    end else begin
      sum_s = {1'b0, hi_r} + (lo_r[0] ? {1'b0, op_r} : {(XLEN+1){1'b0}});
      {hi_nxt_s, lo_nxt_s} = {sum_s, lo_r[XLEN-1:1]};
    end
  end

  // Final result from the last iteration, so Result is ready on entry to DONE.
  always_comb begin
    prod_s = cond_neg_wide({hi_nxt_s, lo_nxt_s}, neg_q_r);
    case (funct3_r)
      3'b000:  fin_s = prod_s[XLEN-1:0];
      3'b001:  fin_s = prod_s[2*XLEN-1:XLEN];
      3'b010:  fin_s = prod_s[2*XLEN-1:XLEN];
      3'b011:  fin_s = prod_s[2*XLEN-1:XLEN];
      3'b100:  fin_s = cond_neg(lo_nxt_s, neg_q_r);
      3'b101:  fin_s = lo_nxt_s;
      3'b110:  fin_s = cond_neg(hi_nxt_s, neg_r_r);
      3'b111:  fin_s = hi_nxt_s;
      default: fin_s = {XLEN{1'b0}};
    endcase
  end

  // Sequencer FSM with registered Done/Busy/Result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= IDLE;
      counter_r <= {CW{1'b0}};
      funct3_r  <= 3'b000;
      is_div_r  <= 1'b0;
      neg_q_r   <= 1'b0;
      neg_r_r   <= 1'b0;
      hi_r      <= {XLEN{1'b0}};
      lo_r      <= {XLEN{1'b0}};
      op_r      <= {XLEN{1'b0}};
      result_r  <= {XLEN{1'b0}};
      done_r    <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          counter_r <= {CW{1'b0}};
          done_r    <= 1'b0;
          if (bus.start && !bus.flush) begin
            funct3_r <= bus.Funct3;
            is_div_r <= bus.Funct3[2];
            neg_q_r  <= a_neg_s ^ b_neg_s;
            neg_r_r  <= a_neg_s;
            hi_r     <= {XLEN{1'b0}};
            lo_r     <= bus.Funct3[2] ? mag_a_s : mag_b_s;
            op_r     <= bus.Funct3[2] ? mag_b_s : mag_a_s;
            busy_r   <= 1'b1;
            if (special_s) begin
              state_r  <= DONE;
              result_r <= special_val_s;
              done_r   <= 1'b1;
            end else begin
              state_r <= RUN;
            end
          end else begin
            busy_r <= 1'b0;
          end
        end
        RUN: begin
          if (bus.flush) begin
            state_r   <= IDLE;
            counter_r <= {CW{1'b0}};
            busy_r    <= 1'b0;
          end else begin
            hi_r <= hi_nxt_s;
            lo_r <= lo_nxt_s;
            if (counter_r == CW'(XLEN-1)) begin
              state_r   <= DONE;
              counter_r <= {CW{1'b0}};
              result_r  <= fin_s;
              done_r    <= 1'b1;
            end else begin
              counter_r <= counter_r + {{(CW-1){1'b0}}, 1'b1};
            end
          end
        end
        DONE: begin
          state_r   <= IDLE;
          counter_r <= {CW{1'b0}};
          done_r    <= 1'b0;
          busy_r    <= 1'b0;
        end
        default: begin
          state_r   <= IDLE;
          counter_r <= {CW{1'b0}};
          done_r    <= 1'b0;
          busy_r    <= 1'b0;
        end
      endcase
    end
  end

  // Stall must rise in the accepting cycle itself, so it is decoded from the live inputs.
  assign bus.Stall  = !reset && (((state_r == IDLE) && bus.start && !bus.flush) || (state_r == RUN));
  assign bus.Busy   = busy_r;
  assign bus.Done   = done_r;
  assign bus.Result = result_r;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed RV32M cases, fast paths, abort paths,
// back-to-back issue and randomized ops against a 64-bit arithmetic reference model.
module tb_muldiv_sequencer;
  logic clk;
  logic reset;
  int   total;
  int   bad;

  muldiv_sequencer_if #(.XLEN(32)) bus ();

  muldiv_sequencer #(.XLEN(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint            sa;
    longint            sb;
    longint unsigned   ua;
    longint unsigned   ub;
    logic [63:0]       p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    p  = 64'd0;
    case (f3)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * longint'(ub); return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin if (b == 32'd0) return 32'hFFFF_FFFF; p = sa / sb; return p[31:0]; end
      3'd5: begin if (b == 32'd0) return 32'hFFFF_FFFF; return a / b; end
      3'd6: begin if (b == 32'd0) return a; p = sa % sb; return p[31:0]; end
      default: begin if (b == 32'd0) return a; return a % b; end
    endcase
  endfunction

  function automatic int ref_latency(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (f3[2] && (b == 32'd0)) return 1;
    if (f3[2] && !f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  // Issue one op at cycle 0 (called just after a rising edge), scramble inputs after
  // acceptance, optionally flush at flush_cyc, and record per-cycle outputs.
  task automatic drive_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input int flush_cyc, input int max_cyc,
                          output int done_cyc, output logic [31:0] res,
                          output logic [127:0] stall_v, output logic [127:0] busy_v,
                          output logic [127:0] done_v);
    bit killed;
    killed   = 1'b0;
    done_cyc = -1;
    res      = 32'd0;
    stall_v  = '0;
    busy_v   = '0;
    done_v   = '0;
    bus.start  = 1'b1;
    bus.flush  = 1'b0;
    bus.Funct3 = f3;
    bus.SrcA   = a;
    bus.SrcB   = b;
    for (int c = 0; c < max_cyc; c++) begin
      if (c > 0) begin
        bus.SrcA   = $urandom;
        bus.SrcB   = $urandom;
        bus.Funct3 = 3'($urandom_range(0, 7));
      end
      if (c == flush_cyc) begin
        bus.flush = 1'b1;
        bus.start = 1'b0;
        killed    = 1'b1;
      end else begin
        bus.flush = 1'b0;
      end
      if (killed || (done_cyc >= 0 && c >= done_cyc + 1)) bus.start = 1'b0;
      @(negedge clk);
      stall_v[c] = bus.Stall;
      busy_v[c]  = bus.Busy;
      done_v[c]  = bus.Done;
      if (bus.Done === 1'b1 && done_cyc < 0) begin
        done_cyc = c;
        res      = bus.Result;
      end
      @(posedge clk);
      #1;
      if (done_cyc >= 0 && c == done_cyc + 1) break;
    end
    bus.start = 1'b0;
    bus.flush = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    total++;
    if ({bus.Stall, bus.Busy, bus.Done} !== 3'b000 || bus.Result !== 32'd0) begin
      bad++;
      $display("FAIL reset_state: got stall/busy/done=%b%b%b result=%h, want 000 result=0",
               bus.Stall, bus.Busy, bus.Done, bus.Result);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_mul_timing();
    int dc; logic [31:0] r; logic [127:0] sv, bv, dv;
    drive_op(3'd0, 32'd7, 32'hFFFF_FFFD, -1, 40, dc, r, sv, bv, dv);
    total++;
    if (dc !== 33 || r !== 32'hFFFF_FFEB) begin
      bad++;
      $display("FAIL mul_neg3: got done_cyc=%0d result=%h, want 33 FFFFFFEB", dc, r);
    end
    total++;
    if (sv[34:0] !== 35'h1_FFFF_FFFF || bv[34:0] !== 35'h3_FFFF_FFFE || dv[34:0] !== 35'h2_0000_0000) begin
      bad++;
      $display("FAIL mul_timing: got stall=%h busy=%h done=%h", sv[34:0], bv[34:0], dv[34:0]);
    end
  endtask

  task automatic test_directed();
    logic [2:0]  f3s [12] = '{3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7, 3'd4, 3'd7, 3'd4, 3'd6, 3'd0};
    logic [31:0] as  [12] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'hFFFF_FFF9,
                              32'd100, 32'd100, 32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000, 32'h1234_5678};
    logic [31:0] bs  [12] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2, 32'd2,
                              32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0};
    logic [31:0] exp [12] = '{32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFFF,
                              32'd14, 32'd2, 32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0, 32'd0};
    int          lat [12] = '{33, 33, 33, 33, 33, 33, 33, 1, 1, 1, 1, 33};
    int dc; logic [31:0] r; logic [127:0] sv, bv, dv;
    for (int i = 0; i < 12; i++) begin
      drive_op(f3s[i], as[i], bs[i], -1, 40, dc, r, sv, bv, dv);
      total++;
      if (dc !== lat[i] || r !== exp[i]) begin
        bad++;
        $display("FAIL directed_%0d: f3=%0d got done_cyc=%0d result=%h, want %0d %h",
                 i, f3s[i], dc, r, lat[i], exp[i]);
      end
      if (lat[i] == 1) begin
        total++;
        if (sv[2:0] !== 3'b001 || dv[2:0] !== 3'b010 || bv[2:0] !== 3'b010) begin
          bad++;
          $display("FAIL fast_timing_%0d: got stall=%b busy=%b done=%b, want 001 010 010",
                   i, sv[2:0], bv[2:0], dv[2:0]);
        end
      end
    end
  endtask

  task automatic test_flush();
    int dc; logic [31:0] r; logic [127:0] sv, bv, dv;
    drive_op(3'd5, 32'd100, 32'd7, -1, 40, dc, r, sv, bv, dv);
    drive_op(3'd0, 32'd9, 32'd9, 10, 60, dc, r, sv, bv, dv);
    total++;
    if (dc !== -1 || dv[59:0] !== 60'd0) begin
      bad++;
      $display("FAIL flush_no_done: got done_cyc=%0d done=%h, want -1 0", dc, dv[59:0]);
    end
    total++;
    if (sv[59:0] !== 60'h7FF || bv[59:0] !== 60'h7FE) begin
      bad++;
      $display("FAIL flush_timing: got stall=%h busy=%h, want 7ff 7fe", sv[59:0], bv[59:0]);
    end
    @(negedge clk);
    total++;
    if (bus.Result !== 32'd14) begin
      bad++;
      $display("FAIL flush_result_kept: got %h want 0000000e", bus.Result);
    end
    @(posedge clk);
    #1;
    bus.start = 1'b1; bus.flush = 1'b1; bus.Funct3 = 3'd0; bus.SrcA = 32'd3; bus.SrcB = 32'd3;
    @(negedge clk);
    total++;
    if (bus.Stall !== 1'b0) begin
      bad++;
      $display("FAIL flush_start_stall: got %b want 0", bus.Stall);
    end
    @(posedge clk);
    #1;
    bus.start = 1'b0; bus.flush = 1'b0;
    @(negedge clk);
    total++;
    if (bus.Busy !== 1'b0) begin
      bad++;
      $display("FAIL flush_start_accept: busy got %b want 0", bus.Busy);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid_run();
    bus.start = 1'b1; bus.Funct3 = 3'd0; bus.SrcA = 32'd5; bus.SrcB = 32'd6;
    repeat (6) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    total++;
    if ({bus.Stall, bus.Busy, bus.Done} !== 3'b000 || bus.Result !== 32'd0) begin
      bad++;
      $display("FAIL reset_mid_run: got stall/busy/done=%b%b%b result=%h, want 000 0",
               bus.Stall, bus.Busy, bus.Done, bus.Result);
    end
    bus.start = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back();
    int d1; int d2; logic [31:0] r1; logic [31:0] r2; bit b34; bit s34; bit extra;
    d1 = -1; d2 = -1; r1 = 32'd0; r2 = 32'd0; b34 = 1'b1; s34 = 1'b0; extra = 1'b0;
    bus.start = 1'b1; bus.flush = 1'b0; bus.Funct3 = 3'd5; bus.SrcA = 32'd100; bus.SrcB = 32'd7;
    for (int c = 0; c < 75; c++) begin
      if (c == 33) begin
        bus.Funct3 = 3'd0; bus.SrcA = 32'h0001_0003; bus.SrcB = 32'hFFFF_FFFF;
      end else if (c > 34) begin
        bus.SrcA = $urandom; bus.SrcB = $urandom;
      end
      if (d2 >= 0) bus.start = 1'b0;
      @(negedge clk);
      if (c == 34) begin b34 = bus.Busy; s34 = bus.Stall; end
      if (bus.Done === 1'b1) begin
        if (d1 < 0) begin d1 = c; r1 = bus.Result; end
        else if (d2 < 0) begin d2 = c; r2 = bus.Result; end
        else extra = 1'b1;
      end
      @(posedge clk);
      #1;
      if (d2 >= 0 && c >= d2 + 1) break;
    end
    bus.start = 1'b0;
    total++;
    if (d1 !== 33 || r1 !== 32'd14) begin
      bad++;
      $display("FAIL b2b_first: got done_cyc=%0d result=%h, want 33 0000000e", d1, r1);
    end
    total++;
    if (d2 !== 67 || r2 !== 32'hFFFE_FFFD || extra) begin
      bad++;
      $display("FAIL b2b_second: got done_cyc=%0d result=%h extra=%b, want 67 fffefffd 0", d2, r2, extra);
    end
    total++;
    if (b34 !== 1'b0 || s34 !== 1'b1) begin
      bad++;
      $display("FAIL b2b_accept_cycle: got busy=%b stall=%b, want 0 1", b34, s34);
    end
  endtask

  task automatic test_random();
    int dc; logic [31:0] r; logic [127:0] sv, bv, dv;
    logic [2:0] f3; logic [31:0] a; logic [31:0] b;
    logic [31:0] picks [3] = '{32'd0, 32'h8000_0000, 32'hFFFF_FFFF};
    for (int i = 0; i < 40; i++) begin
      f3 = 3'($urandom_range(0, 7));
      a  = ($urandom_range(0, 3) == 0) ? picks[$urandom_range(0, 2)] : $urandom;
      b  = ($urandom_range(0, 3) == 0) ? picks[$urandom_range(0, 2)] : $urandom;
      drive_op(f3, a, b, -1, 40, dc, r, sv, bv, dv);
      total++;
      if (dc !== ref_latency(f3, a, b) || r !== ref_result(f3, a, b)) begin
        bad++;
        $display("FAIL random_%0d: f3=%0d a=%h b=%h got cyc=%0d res=%h, want cyc=%0d res=%h",
                 i, f3, a, b, dc, r, ref_latency(f3, a, b), ref_result(f3, a, b));
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    bus.start = 1'b0; bus.flush = 1'b0; bus.Funct3 = 3'd0; bus.SrcA = 32'd0; bus.SrcB = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    reset = 1'b0;
    @(posedge clk);
    #1;
    test_mul_timing();
    test_directed();
    test_flush();
    test_reset_mid_run();
    test_reset();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
